walk_request_bank: RTL and testbench
====================================

Name: walk_request_bank

Overview:
Parametrised multi-crossing successor to the single walk-request register. It conditions N raw pedestrian push-button inputs: synchroniser, debounce, rising-edge detect. Each press is latched as a pending walk request per channel. A round-robin arbiter with age-based urgency presents one request at a time to the traffic-light controller FSM, which acknowledges service. The block sits between the board button pins and the main controller.

Parameters:
N_CH, 4, number of pedestrian crossings (2..16)
SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before the debounced level changes (>=1)
MAX_WAIT, 1000, cycles a request may pend before it becomes urgent (>=1)
WAIT_W, clog2(MAX_WAIT+1), width of each wait counter (derived, localparam)
IDX_W, clog2(N_CH) (min 1), width of the grant index (derived, localparam)

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
WR_Sync  in  N_CH  raw, asynchronous button inputs, one bit per crossing
WR_Reset  in  N_CH  per-channel synchronous clear of the pending request (controller override)
grant_ack  in  1  one-cycle pulse: controller has served the currently granted channel
WR  out  N_CH  registered pending-request flags
urgent  out  N_CH  registered; channel has pended for MAX_WAIT cycles
grant_valid  out  1  combinational: at least one WR bit is set
grant_idx  out  IDX_W  combinational: channel currently offered for service

Behaviour:
- Reset: WR=0, urgent=0, synchroniser flops=0, debounced levels=0, debounce counters=0, wait counters=0, rr_ptr=0. Consequently grant_valid=0 and grant_idx=0.
- Synchroniser: WR_Sync[i] passes through SYNC_STAGES flops, giving s[i].
- Debounce: a counter runs while s[i] != deb[i] and clears when they match. When s[i] has differed for DEBOUNCE_CYCLES consecutive cycles, deb[i] <= s[i] and the counter clears. Glitches shorter than DEBOUNCE_CYCLES never reach deb[i].
- Edge detect: rise[i] = deb[i] & ~deb_q[i]. It is a single-cycle pulse, so holding the button produces exactly one request.
- Latency: a raw input held high from clock edge 0 sets WR[i] at edge SYNC_STAGES+DEBOUNCE_CYCLES+1. With defaults this is edge 7.
- WR[i] next-state priority, highest first:
  1. rise[i]: set. A new press wins over a clear in the same cycle, so the press is not lost.
  2. WR_Reset[i], or (grant_ack & grant_valid & grant_idx==i): clear.
  3. Otherwise hold.
- Re-press while WR[i]=1: no effect; no request count is kept.
- Wait counter i: counts up while WR[i]=1 and saturates at MAX_WAIT. It clears on the cycle WR[i] clears, and also on a set-over-clear collision, where the request is treated as fresh.
- urgent[i] is registered and equals (wait_cnt[i]==MAX_WAIT).
- Arbiter (combinational from registered WR, urgent, rr_ptr):
  - If any urgent bit is set, grant the lowest-index urgent channel.
  - Otherwise grant the first set WR bit searching rr_ptr, rr_ptr+1, … with wrap modulo N_CH.
  - grant_valid = |WR. When grant_valid=0, grant_idx=0.
- rr_ptr updates only on an accepted ack (grant_ack & grant_valid): rr_ptr <= (grant_idx+1) mod N_CH. An ack with grant_valid=0 is ignored and changes no state.
- An ack and a WR_Reset on the same channel together give a single clear; the pointer still advances.
- Reset asserted mid-operation: all state clears asynchronously. Any button still held must produce a fresh debounced rise after reset deasserts, i.e. latency restarts from 0.

Decomposition:
- Package walk_pkg:
  - clog2 function
  - default constants: N_CH_DEF, SYNC_STAGES_DEF, DEBOUNCE_DEF, MAX_WAIT_DEF
- Sub-module walk_input_conditioner: one-channel synchroniser, debounce and rise pulse, instantiated N_CH times in a generate loop.
- Request latch, wait counters, urgency and arbiter stay in the top level.

Test Plan:
- Reset then idle → WR=0000, urgent=0000, grant_valid=0, grant_idx=0. Assert reset mid-count → all outputs 0 immediately, without waiting for a clock edge.
- Hold WR_Sync[1]=1 from edge 0 → WR=0010 exactly at edge 7 (defaults); grant_valid=1, grant_idx=1. Release and re-hold → no change while WR[1]=1.
- 3-cycle pulse on WR_Sync[2] → WR stays 0000 (debounce rejects). A 2-cycle dip while held → no second rise.
- Requests set on ch0, ch2, ch3, rr_ptr=0, ack every grant → grants served in order 0, 2, 3. New ch0 request after the ack of 2 → next grants 3 then 0.
- ch1 rise in the same cycle as WR_Reset[1]=1 → WR[1]=1 and wait_cnt restarts. WR_Reset[1] alone → WR[1]=0 next edge.
- MAX_WAIT=8 with ch3 pending and ch1 newer; no ack for 8 cycles → urgent=1000 and grant_idx=3 even when rr_ptr=1. Ack → WR[3]=0, urgent=0000, rr_ptr=0.

Source files
------------

// File: rtl/walk_pkg.sv
// walk_pkg
// Shared constants and helpers for the pedestrian walk-request bank.
//   N_CH_DEF        default number of crossings
//   SYNC_STAGES_DEF default synchroniser depth
//   DEBOUNCE_DEF    default debounce length in cycles
//   MAX_WAIT_DEF    default cycles before a pending request turns urgent
//   clog2()         ceiling log2, usable in parameter expressions
package walk_pkg;

  localparam int N_CH_DEF        = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_DEF    = 4;
  localparam int MAX_WAIT_DEF    = 1000;

  // Smallest r with 2**r >= value; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/walk_input_conditioner.sv
// walk_input_conditioner
// One-channel button conditioning: multi-flop synchroniser, stability
// debounce and a one-cycle rising-edge pulse of the debounced level.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous active-high reset, clears every flop
//   raw_i   in   raw asynchronous button level
//   rise_o  out  one-cycle pulse when the debounced level goes 0 -> 1
import walk_pkg::*;

module walk_input_conditioner #(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic rise_o
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   deb_q, deb_d;
  logic                   deb_prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sync_level;

  assign sync_level = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  // The counter tracks how many consecutive cycles the synchronised level
  // has disagreed with the debounced level. Any agreement restarts it, so
  // a glitch shorter than DEBOUNCE_CYCLES never flips the debounced level.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_level != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync_level;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  // deb_prev_q also clears on reset, so a button held through reset
  // produces a fresh pulse once it has been re-debounced.
  assign rise_o = deb_q & ~deb_prev_q;

endmodule

// File: rtl/walk_request_bank.sv
// walk_request_bank
// Conditions N_CH pedestrian buttons, latches one pending walk request per
// crossing, ages each request and offers one request at a time to the
// traffic-light controller.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   WR_Sync      in   raw button levels, one per crossing
//   WR_Reset     in   per-crossing synchronous clear of the pending request
//   grant_ack    in   one-cycle pulse: controller served the offered crossing
//   WR           out  registered pending-request flags
//   urgent       out  registered: request has pended MAX_WAIT cycles
//   grant_valid  out  combinational: some request is pending
//   grant_idx    out  combinational: crossing currently offered
//
// Handshake: grant_valid/grant_idx form the offer and may change every
// cycle. grant_ack is an accept strobe that only takes effect while
// grant_valid is high; it then clears the offered request and moves the
// round-robin pointer one past it. An ack with grant_valid low is ignored.
import walk_pkg::*;

module walk_request_bank #(
  parameter int  N_CH            = N_CH_DEF,
  parameter int  SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int  DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int  MAX_WAIT        = MAX_WAIT_DEF,
  localparam int WAIT_W          = clog2(MAX_WAIT + 1),
  localparam int IDX_W           = (N_CH > 2) ? clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  WR_Sync,
  input  logic [N_CH-1:0]  WR_Reset,
  input  logic             grant_ack,
  output logic [N_CH-1:0]  WR,
  output logic [N_CH-1:0]  urgent,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [N_CH-1:0]   rise_c;
  logic [N_CH-1:0]   clr_c;
  logic              ack_ok_c;
  logic [N_CH-1:0]   wr_q, wr_d;
  logic [N_CH-1:0]   urgent_q, urgent_d;
  logic [WAIT_W-1:0] wait_q [N_CH];
  logic [WAIT_W-1:0] wait_d [N_CH];
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic              found_c;
  logic [IDX_W:0]    cand_c;

  // Input conditioning, one instance per crossing.
  for (genvar g = 0; g < N_CH; g++) begin : g_cond
    walk_input_conditioner #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cond (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (WR_Sync[g]),
      .rise_o (rise_c[g])
    );
  end

  // Arbiter: urgency first (lowest index wins), then round-robin
  // starting at rr_q and wrapping modulo N_CH.
  always_comb begin
    grant_idx = '0;
    found_c   = 1'b0;
    cand_c    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found_c && urgent_q[i]) begin
        grant_idx = IDX_W'(i);
        found_c   = 1'b1;
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      cand_c = {1'b0, rr_q} + (IDX_W + 1)'(k);
      if (cand_c >= (IDX_W + 1)'(N_CH)) begin
        cand_c = cand_c - (IDX_W + 1)'(N_CH);
      end
      if (!found_c && wr_q[cand_c[IDX_W-1:0]]) begin
        grant_idx = cand_c[IDX_W-1:0];
        found_c   = 1'b1;
      end
    end
  end

  assign grant_valid = |wr_q;
  assign ack_ok_c    = grant_ack & grant_valid;

  // A controller override and an accepted ack on the same crossing
  // collapse into one clear.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      clr_c[i] = WR_Reset[i] | (ack_ok_c & (grant_idx == IDX_W'(i)));
    end
  end

  // Request latch and ageing. A rise beats a clear so a press landing on
  // the service cycle is kept; that request is then treated as new and
  // its age restarts.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      wr_d[i]   = wr_q[i];
      wait_d[i] = wait_q[i];
      if (rise_c[i]) begin
        wr_d[i] = 1'b1;
      end else if (clr_c[i]) begin
        wr_d[i] = 1'b0;
      end
      if (!wr_d[i] || (rise_c[i] && clr_c[i])) begin
        wait_d[i] = '0;
      end else if (wr_q[i] && (wait_q[i] != WAIT_W'(MAX_WAIT))) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
      // Registered from the next age so urgent tracks wait_q exactly.
      urgent_d[i] = (wait_d[i] == WAIT_W'(MAX_WAIT));
    end
  end

  // Pointer moves one past the served crossing, only on an accepted ack.
  always_comb begin
    rr_d = rr_q;
    if (ack_ok_c) begin
      if (grant_idx == IDX_W'(N_CH - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q     <= '0;
      urgent_q <= '0;
      rr_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      wr_q     <= wr_d;
      urgent_q <= urgent_d;
      rr_q     <= rr_d;
      for (int i = 0; i < N_CH; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign WR     = wr_q;
  assign urgent = urgent_q;

endmodule

// File: tb/tb_walk_request_bank.sv
module tb_walk_request_bank;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int MAXW = 8;
  localparam int IW   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  WR_Sync;
  logic [N-1:0]  WR_Reset;
  logic          grant_ack;
  logic [N-1:0]  WR;
  logic [N-1:0]  urgent;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;

  int tests_run = 0;
  int fails     = 0;

  walk_request_bank #(
    .N_CH            (N),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .MAX_WAIT        (MAXW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .WR_Sync     (WR_Sync),
    .WR_Reset    (WR_Reset),
    .grant_ack   (grant_ack),
    .WR          (WR),
    .urgent      (urgent),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw samples and synchronised samples kept as shift histories; the
  // debounced level flips once the last DEB synchronised samples all
  // disagree with it.
  logic [63:0] m_raw_hist [N];
  logic [63:0] m_s_hist   [N];
  bit          m_deb  [N];
  bit          m_rise [N];
  bit          m_wr   [N];
  int          m_wait [N];
  int          m_rr;

  function automatic int model_grant();
    for (int i = 0; i < N; i++) if (m_wr[i] && m_wait[i] == MAXW) return i;
    for (int k = 0; k < N; k++) if (m_wr[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int g;
    bit clr;
    bit s_now;
    logic [63:0] mask;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_raw_hist[i] = '0; m_s_hist[i] = '0;
        m_deb[i] = 0; m_rise[i] = 0; m_wr[i] = 0; m_wait[i] = 0;
      end
      m_rr = 0;
    end else begin
      g = model_grant();
      for (int i = 0; i < N; i++) begin
        clr = WR_Reset[i] || (grant_ack && g == i);
        if (m_rise[i]) begin
          if (clr) m_wait[i] = 0;
          else if (m_wr[i] && m_wait[i] < MAXW) m_wait[i]++;
          m_wr[i] = 1;
        end else if (clr) begin
          m_wr[i] = 0; m_wait[i] = 0;
        end else if (m_wr[i] && m_wait[i] < MAXW) begin
          m_wait[i]++;
        end
      end
      if (grant_ack && g >= 0) m_rr = (g + 1) % N;
      mask = (64'd1 << DEB) - 64'd1;
      for (int i = 0; i < N; i++) begin
        s_now = m_raw_hist[i][SYNC-1];
        m_raw_hist[i] = {m_raw_hist[i][62:0], WR_Sync[i]};
        m_s_hist[i]   = {m_s_hist[i][62:0], s_now};
        m_rise[i] = 0;
        if (!m_deb[i] && ((m_s_hist[i] & mask) == mask)) begin
          m_deb[i] = 1; m_rise[i] = 1;
        end else if (m_deb[i] && ((m_s_hist[i] & mask) == 64'd0)) begin
          m_deb[i] = 0;
        end
      end
    end
  end

  // ---------------- per-cycle scoreboard compare ----------------
  always @(negedge clk) begin : compare
    int g;
    logic [N-1:0] exp_wr, exp_urg;
    g = model_grant();
    for (int i = 0; i < N; i++) begin
      exp_wr[i]  = m_wr[i];
      exp_urg[i] = (m_wait[i] == MAXW);
    end
    chk("cyc_wr", WR, exp_wr);
    chk("cyc_urgent", urgent, exp_urg);
    chk("cyc_gvalid", grant_valid, (g >= 0));
    chk("cyc_gidx", grant_idx, (g >= 0) ? g : 0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    grant_ack = 1'b1;
    tick(1);
    grant_ack = 1'b0;
  endtask

  task automatic do_reset();
    WR_Sync = '0; WR_Reset = '0; grant_ack = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_wr(input logic [N-1:0] m, input int budget, input string nm);
    int c;
    c = 0;
    while (((WR & m) != m) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(nm, ((WR & m) == m), 1);
  endtask

  // ---------------- stimulus ----------------
  int hold [N];

  initial begin
    reset = 1'b1; WR_Sync = '0; WR_Reset = '0; grant_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("rst_wr", WR, 4'b0000);
    chk("rst_urgent", urgent, 4'b0000);
    chk("rst_gvalid", grant_valid, 0);
    chk("rst_gidx", grant_idx, 0);
    ack_pulse();
    chk("idle_ack_gvalid", grant_valid, 0);

    // Latency and re-press on ch1.
    WR_Sync[1] = 1'b1;
    tick(6);
    chk("lat_edge6", WR, 4'b0000);
    tick(1);
    chk("lat_edge7", WR, 4'b0010);
    chk("lat_gvalid", grant_valid, 1);
    chk("lat_gidx", grant_idx, 1);
    WR_Sync[1] = 1'b0;
    tick(8);
    WR_Sync[1] = 1'b1;
    tick(10);
    chk("repress_wr", WR, 4'b0010);
    chk("repress_urgent", urgent, 4'b0010);
    WR_Reset[1] = 1'b1;
    tick(1);
    WR_Reset[1] = 1'b0;
    chk("wrreset_wr", WR, 4'b0000);
    chk("wrreset_urgent", urgent, 4'b0000);
    WR_Sync[1] = 1'b0;
    tick(10);

    // Glitch rejection and dip while held on ch2.
    WR_Sync[2] = 1'b1;
    tick(3);
    WR_Sync[2] = 1'b0;
    tick(12);
    chk("glitch_wr", WR, 4'b0000);
    WR_Sync[2] = 1'b1;
    tick(7);
    chk("hold2_wr", WR, 4'b0100);
    ack_pulse();
    chk("ack2_wr", WR, 4'b0000);
    WR_Sync[2] = 1'b0;
    tick(2);
    WR_Sync[2] = 1'b1;
    tick(12);
    chk("dip_wr", WR, 4'b0000);
    WR_Sync[2] = 1'b0;
    tick(10);

    // Set-over-clear collision on ch1.
    WR_Sync[1] = 1'b1;
    tick(7);
    chk("col_set_wr", WR, 4'b0010);
    WR_Sync[1] = 1'b0;
    tick(12);
    chk("col_old_urgent", urgent, 4'b0010);
    WR_Sync[1] = 1'b1;
    tick(6);
    WR_Reset[1] = 1'b1;
    tick(1);
    WR_Reset[1] = 1'b0;
    chk("col_wr", WR, 4'b0010);
    chk("col_urgent", urgent, 4'b0000);
    tick(3);
    chk("col_urgent_later", urgent, 4'b0000);
    WR_Reset[1] = 1'b1;
    tick(1);
    WR_Reset[1] = 1'b0;
    chk("col_clear_wr", WR, 4'b0000);
    WR_Sync[1] = 1'b0;

    // Urgency overriding round-robin: rr_ptr=1, ch3 older than ch1.
    WR_Sync[0] = 1'b1;
    tick(7);
    chk("urg_ch0_gidx", grant_idx, 0);
    ack_pulse();
    WR_Sync[0] = 1'b0;
    chk("urg_ch0_wr", WR, 4'b0000);
    WR_Sync[3] = 1'b1;
    tick(2);
    WR_Sync[1] = 1'b1;
    tick(5);
    chk("urg_t7_wr", WR, 4'b1000);
    tick(2);
    chk("urg_t9_wr", WR, 4'b1010);
    chk("urg_t9_gidx", grant_idx, 1);
    tick(5);
    chk("urg_t14_urgent", urgent, 4'b0000);
    tick(1);
    chk("urg_t15_urgent", urgent, 4'b1000);
    chk("urg_t15_gidx", grant_idx, 3);
    ack_pulse();
    chk("urg_ack_wr", WR, 4'b0010);
    chk("urg_ack_urgent", urgent, 4'b0000);
    chk("urg_ack_gidx", grant_idx, 1);
    WR_Sync[3] = 1'b0;

    // Asynchronous reset mid-operation while ch1 stays held.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_wr", WR, 4'b0000);
    chk("async_rst_urgent", urgent, 4'b0000);
    chk("async_rst_gvalid", grant_valid, 0);
    chk("async_rst_gidx", grant_idx, 0);
    @(negedge clk);
    reset = 1'b0;
    tick(6);
    chk("post_rst_edge6", WR, 4'b0000);
    tick(1);
    chk("post_rst_edge7", WR, 4'b0010);
    WR_Sync[1] = 1'b0;

    // Round-robin service order.
    do_reset();
    WR_Sync = 4'b1101;
    tick(6);
    chk("rr_edge6", WR, 4'b0000);
    tick(1);
    chk("rr_set_wr", WR, 4'b1101);
    chk("rr_first", grant_idx, 0);
    WR_Sync = 4'b0000;
    grant_ack = 1'b1;
    tick(1);
    chk("rr_after0_wr", WR, 4'b1100);
    chk("rr_second", grant_idx, 2);
    tick(1);
    grant_ack = 1'b0;
    chk("rr_after2_wr", WR, 4'b1000);
    chk("rr_third", grant_idx, 3);
    tick(5);
    WR_Sync[0] = 1'b1;
    wait_wr(4'b0001, 20, "rr_ch0_again");
    chk("rr_next3", grant_idx, 3);
    ack_pulse();
    chk("rr_after3_wr", WR, 4'b0001);
    chk("rr_next0", grant_idx, 0);
    ack_pulse();
    chk("rr_empty", WR, 4'b0000);
    WR_Sync[0] = 1'b0;

    // Randomized phase, checked by the per-cycle compare.
    do_reset();
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          WR_Sync[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 12);
        end else begin
          hold[i]--;
        end
        WR_Reset[i] = ($urandom_range(0, 31) == 0);
      end
      grant_ack = ($urandom_range(0, 3) == 0);
      if (cyc == 1200) begin
        #2 reset = 1'b1;
        #1;
        chk("rand_rst_wr", WR, 4'b0000);
        chk("rand_rst_gvalid", grant_valid, 0);
        @(negedge clk);
        reset = 1'b0;
      end
    end
    WR_Sync = '0; WR_Reset = '0; grant_ack = 1'b0;
    tick(20);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
